// File: rtl/sentinel_audit_arbiter_pkg.sv
// rtl/sentinel_audit_arbiter_pkg.sv - shared constants, record type and FSM states for the audit arbiter
package sentinel_pkg;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_VETO     = 2'b01;
    localparam logic [1:0] ST_THERMAL  = 2'b10;
    localparam logic [1:0] ST_AI_FAULT = 2'b11;

    // Record fields are sized for the largest supported build (16 channels, 32-bit stamp).
    localparam int REC_CH_W = 4;
    localparam int REC_TS_W = 32;

    typedef struct packed {
        logic [REC_CH_W-1:0] ch;
        logic [1:0]          code;
        logic [REC_TS_W-1:0] ts;
    } audit_rec_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/sentinel_audit_arbiter_if.sv
// rtl/sentinel_audit_arbiter_if.sv - audit-log write port bundle
interface sentinel_audit_arbiter_if #(
    parameter int N_CH = 4,
    parameter int TS_W = 16
) ();
    localparam int CH_W = $clog2(N_CH);

    logic            log_valid;
    logic            log_ready;
    logic [CH_W-1:0] log_ch;
    logic [1:0]      log_code;
    logic [TS_W-1:0] log_ts;

    modport master (output log_valid, output log_ch, output log_code, output log_ts, input log_ready);
    modport slave  (input log_valid, input log_ch, input log_code, input log_ts, output log_ready);
endinterface

// File: rtl/sentinel_audit_arbiter_rr.sv
// rtl/sentinel_audit_arbiter_rr.sv - combinational round-robin pick starting after the last grant
module sentinel_rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last,
    output logic            grant_valid,
    output logic [CH_W-1:0] grant_idx
);
    int cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = (int'(last) + i) % N_CH;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(cand);
            end
        end
    end
endmodule

// File: rtl/sentinel_audit_arbiter.sv
// rtl/sentinel_audit_arbiter.sv - per-channel OK-to-unsafe event capture, one slot per channel,
// round-robin serialisation onto the audit-log port with drop accounting
module sentinel_audit_arbiter
    import sentinel_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int TS_W   = 16,
    parameter int DROP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*N_CH-1:0]     status_in,
    sentinel_audit_arbiter_if.master log_port,
    output logic [N_CH-1:0]       pending_mask,
    output logic [DROP_W-1:0]     drop_count,
    output logic                  overflow_latched
);
    localparam int CH_W = $clog2(N_CH);

    logic [TS_W-1:0]   ts;
    logic [2*N_CH-1:0] prev_status;
    logic [1:0]        slot_code [N_CH];
    logic [TS_W-1:0]   slot_ts   [N_CH];
    logic [CH_W-1:0]   rr;
    out_state_t        state, state_nx;
    audit_rec_t        out_rec;

    logic              take, load, grant_valid;
    logic [CH_W-1:0]   grant_idx;
    logic [N_CH-1:0]   evt, granted, drop_vec;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_next;
    int                n_drop;

    sentinel_rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_rr (
        .req         (pending_mask),
        .last        (rr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            OUT_EMPTY: begin
                take = 1'b1;
                if (grant_valid) state_nx = OUT_FULL;
            end
            OUT_FULL: begin
                if (log_port.log_ready) begin
                    take = 1'b1;
                    if (!grant_valid) state_nx = OUT_EMPTY;
                end
            end
            default: state_nx = OUT_EMPTY;
        endcase
        load = take && grant_valid;
    end

    // A slot being granted this edge frees up in time to take a same-edge event.
    always_comb begin
        evt      = '0;
        granted  = '0;
        drop_vec = '0;
        n_drop   = 0;
        for (int i = 0; i < N_CH; i++) begin
            evt[i]      = (prev_status[2*i +: 2] == ST_OK) && (status_in[2*i +: 2] != ST_OK);
            granted[i]  = load && (grant_idx == CH_W'(i));
            drop_vec[i] = evt[i] && pending_mask[i] && !granted[i];
            n_drop      = n_drop + int'(drop_vec[i]);
        end
        drop_sum  = {1'b0, drop_count} + (DROP_W+1)'(n_drop);
        drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts               <= '0;
            prev_status      <= '0;
            pending_mask     <= '0;
            drop_count       <= '0;
            overflow_latched <= 1'b0;
            rr               <= CH_W'(N_CH-1);
            state            <= OUT_EMPTY;
            out_rec          <= '0;
            for (int i = 0; i < N_CH; i++) begin
                slot_code[i] <= ST_OK;
                slot_ts[i]   <= '0;
            end
        end else begin
            ts          <= ts + 1'b1;
            prev_status <= status_in;
            state       <= state_nx;
            for (int i = 0; i < N_CH; i++) begin
                if (evt[i] && (!pending_mask[i] || granted[i])) begin
                    slot_code[i]    <= status_in[2*i +: 2];
                    slot_ts[i]      <= ts;
                    pending_mask[i] <= 1'b1;
                end else if (granted[i]) begin
                    pending_mask[i] <= 1'b0;
                end
            end
            if (|drop_vec) begin
                drop_count       <= drop_next;
                overflow_latched <= 1'b1;
            end
            if (load) begin
                out_rec.ch   <= REC_CH_W'(grant_idx);
                out_rec.code <= slot_code[grant_idx];
                out_rec.ts   <= REC_TS_W'(slot_ts[grant_idx]);
                rr           <= grant_idx;
            end
        end
    end

    assign log_port.log_valid = (state == OUT_FULL);
    assign log_port.log_ch    = out_rec.ch[CH_W-1:0];
    assign log_port.log_code  = out_rec.code;
    assign log_port.log_ts    = out_rec.ts[TS_W-1:0];
endmodule

// File: tb/tb_sentinel_audit_arbiter.sv
// tb/tb_sentinel_audit_arbiter.sv - scoreboard bench for sentinel_audit_arbiter
module tb_sentinel_audit_arbiter;

    typedef struct packed {
        logic [1:0]  ch;
        logic [1:0]  code;
        logic [15:0] ts;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  status = '0;
    logic [3:0]  pmask;
    logic [7:0]  dcnt;
    logic        ovf;
    logic [15:0] ts_model = '0;
    logic [15:0] hold_ts;
    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    int          xfers = 0;
    int          base;

    sentinel_audit_arbiter_if #(.N_CH(4), .TS_W(16)) bus ();

    sentinel_audit_arbiter #(.N_CH(4), .TS_W(16), .DROP_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .status_in        (status),
        .log_port         (bus),
        .pending_mask     (pmask),
        .drop_count       (dcnt),
        .overflow_latched (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) ts_model <= '0;
        else        ts_model <= ts_model + 16'd1;
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.log_valid && bus.log_ready) begin
            xfers++;
            if (sb.size() == 0) begin
                check("unexpected_record", 32'(bus.log_ch), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("log_ch",   32'(bus.log_ch),   32'(e.ch));
                check("log_code", 32'(bus.log_code), 32'(e.code));
                check("log_ts",   32'(bus.log_ts),   32'(e.ts));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ch(int ch, logic [1:0] code);
        status[2*ch +: 2] = code;
    endtask

    task automatic push(int ch, logic [1:0] code);
        sb.push_back('{ch: 2'(ch), code: code, ts: ts_model});
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        status = '0;
        sb.delete();
        step();
        check("rst_log_valid", 32'(bus.log_valid), 32'd0);
        check("rst_log_ch",    32'(bus.log_ch),    32'd0);
        check("rst_log_code",  32'(bus.log_code),  32'd0);
        check("rst_log_ts",    32'(bus.log_ts),    32'd0);
        check("rst_pending",   32'(pmask),         32'd0);
        check("rst_drop",      32'(dcnt),          32'd0);
        check("rst_overflow",  32'(ovf),           32'd0);
        rst_n = 1'b1;
    endtask

    task automatic drain(int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) step();
        step();
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.log_ready = 1'b1;
        step();
        do_reset();

        // single event, latency, then held status gives no more records
        step();
        set_ch(2, 2'b10);
        push(2, 2'b10);
        base = xfers;
        step();
        check("lat_pending", 32'(pmask), 32'b0100);
        check("lat_valid0",  32'(bus.log_valid), 32'd0);
        step();
        check("lat_valid1",  32'(bus.log_valid), 32'd1);
        repeat (20) step();
        check("single_xfers", 32'(xfers - base), 32'd1);
        check("single_valid_gone", 32'(bus.log_valid), 32'd0);

        // all four channels at once: round-robin order 0..3, one per cycle
        do_reset();
        for (int c = 0; c < 4; c++) set_ch(c, 2'b01);
        for (int c = 0; c < 4; c++) push(c, 2'b01);
        base = xfers;
        repeat (6) step();
        check("b2b_xfers", 32'(xfers - base), 32'd4);
        drain(10);
        check("b2b_drop", 32'(dcnt), 32'd0);

        // blocked sink: hold stability, slot occupancy, single drop
        status = '0;
        repeat (2) step();
        bus.log_ready = 1'b0;
        set_ch(0, 2'b01);
        push(0, 2'b01);
        hold_ts = ts_model;
        repeat (3) step();
        check("hold_valid", 32'(bus.log_valid), 32'd1);
        set_ch(1, 2'b11);
        set_ch(0, 2'b11);
        push(1, 2'b11);
        step();
        set_ch(1, 2'b00);
        step();
        set_ch(1, 2'b11);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_ch",   32'(bus.log_ch),   32'd0);
            check("hold_code", 32'(bus.log_code), 32'd1);
            check("hold_ts",   32'(bus.log_ts),   32'(hold_ts));
        end
        check("hold_pending",  32'(pmask), 32'b0010);
        check("drop_one",      32'(dcnt),  32'd1);
        check("overflow_one",  32'(ovf),   32'd1);
        bus.log_ready = 1'b1;
        drain(10);

        // saturating drop counter
        status = '0;
        repeat (2) step();
        bus.log_ready = 1'b0;
        set_ch(0, 2'b01);
        push(0, 2'b01);
        repeat (3) step();
        set_ch(1, 2'b11);
        push(1, 2'b11);
        step();
        for (int i = 0; i < 300; i++) begin
            set_ch(1, 2'b00);
            step();
            set_ch(1, 2'b11);
            step();
        end
        check("drop_sat",     32'(dcnt), 32'd255);
        check("overflow_sat", 32'(ovf),  32'd1);
        for (int i = 0; i < 5; i++) begin
            set_ch(1, 2'b00);
            step();
            set_ch(1, 2'b11);
            step();
        end
        check("drop_sat_stay", 32'(dcnt), 32'd255);

        // mid-operation reset with a presented record and two pending slots
        set_ch(3, 2'b01);
        step();
        check("pre_rst_pending", 32'(pmask), 32'b1010);
        check("pre_rst_valid",   32'(bus.log_valid), 32'd1);
        do_reset();
        bus.log_ready = 1'b1;
        set_ch(0, 2'b01);
        set_ch(3, 2'b10);
        push(0, 2'b01);
        push(3, 2'b10);
        check("post_rst_ts_model", 32'(ts_model), 32'd0);
        drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sentinel_audit_arbiter.md
Name: sentinel_audit_arbiter

Overview:
Multi-channel audit sequencer for the Sentinel-X edge monitor path.
- Watches N_CH per-channel 2-bit status codes (one per monitored AI/vehicle channel) and detects OK-to-unsafe transitions.
- Queues one pending event per channel, each stamped with a free-running timestamp.
- Serialises events round-robin onto a single valid/ready audit-log write port.
- Sits between the per-channel status sources and the audit-log storage/uplink; accounts for every event it cannot hold.

Parameters:
- N_CH, 4, number of monitored channels (2..16).
- TS_W, 16, timestamp counter width.
- DROP_W, 8, dropped-event counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; synchronous, active-low
- status_in  in  2*N_CH  per-channel status. Channel i occupies bits [2i+1:2i]. Codes: 00=OK, 01=VETO, 10=THERMAL, 11=AI FAULT.
- log_ready  in  1  audit-log sink accepts record
- log_valid  out  1  record presented
- log_ch  out  CH_W=$clog2(N_CH)  channel index of record
- log_code  out  2  status code captured at event
- log_ts  out  TS_W  timestamp captured at event
- pending_mask  out  N_CH  per-channel pending-slot occupancy
- drop_count  out  DROP_W  saturating count of lost events
- overflow_latched  out  1  sticky: at least one event lost since reset

Behaviour:
- Reset (rst_n=0 at a clk edge) forces the following; applies identically mid-operation, and any presented or pending record is discarded:
  - log_valid=0; log_ch=0; log_code=00; log_ts=0.
  - pending_mask=0; drop_count=0; overflow_latched=0.
  - All prev_status=00; ts=0; rr pointer=N_CH-1, so channel 0 has first priority.
- Timestamp ts: increments every cycle out of reset; wraps from 2^TS_W-1 to 0 with no flag.
- Event on channel i:
  - Condition: prev_status[i]==00 && status_in[i]!=00. prev_status[i] updates every cycle.
  - Non-OK to different non-OK (e.g. 01->11) is NOT an event.
  - A channel held non-OK produces exactly one event.
- Pending slot i holds {code, ts}. On event at edge k:
  - Slot empty, or slot granted to output at the same edge: load {status_in[i], ts current value}. No drop.
  - Slot occupied and not granted at that edge: discard the new event (slot keeps the older event). drop_count += 1, saturating at all-ones; overflow_latched <= 1.
  - Multiple channels with events at the same edge are handled independently per channel.
- Output register FSM, states OUT_EMPTY and OUT_FULL:
  - "Load" = pick the first set pending bit searching from rr+1 mod N_CH upward with wrap. Copy that slot to log_*, clear its bit, set rr to the picked index.
  - OUT_EMPTY: any pending bit set -> load, go OUT_FULL.
  - OUT_FULL, log_ready=0: hold all log_* stable; no change.
  - OUT_FULL, log_ready=1 (transfer): if any pending bit set, load the next record in the same cycle (back-to-back, one record per cycle sustained); else go OUT_EMPTY.
- log_valid=1 exactly in OUT_FULL.
- Latency with sink always ready: status change presented before edge k -> pending bit set after k -> log_valid after k+1. Two-cycle event-to-valid latency.
- Fairness: with all channels continuously pending, each channel is granted once per N_CH transfers.
- log_ready while log_valid=0 has no effect.

Decomposition:
- Shared package sentinel_pkg:
  - Status constants ST_OK=2'b00, ST_VETO=2'b01, ST_THERMAL=2'b10, ST_AI_FAULT=2'b11.
  - Audit record typedef {ch, code, ts} (parameterised widths via localparams).
  - Output FSM state enum.
- Sub-module sentinel_rr_arbiter: combinational N_CH-wide round-robin pick.
  - Inputs: request mask, last-grant pointer.
  - Outputs: grant_valid, grant_idx.
- Parent holds edge detect, slots, timestamp, counters and the output FSM.

Test Plan:
- Reset, then ch2 status 00->10 while log_ready=1 -> log_valid two cycles later for one cycle with log_ch=2, log_code=10, log_ts = ts at detection; ch2 held at 10 for 20 cycles -> no further records.
- Channels 0..3 all 00->01 on the same cycle, log_ready=1 -> four consecutive records, ch order 0,1,2,3, identical log_ts; drop_count=0.
- log_ready=0; ch1 toggles 00->11->00->11 (two events) -> first held in slot, second dropped: drop_count=1, overflow_latched=1. Raise log_ready -> only first event emitted, log_code=11.
- log_ready=0 with record on ch0 presented -> log_ch/log_code/log_ts stable for 10 cycles; ch0 status 01->11 during hold -> no new event, pending_mask[0]=0.
- Force 300 drops on a blocked channel -> drop_count saturates at 255 and stays.
- Assert rst_n=0 for one edge while log_valid=1 and pending_mask=4'b1010 -> next cycle all outputs zero, ts=0. Then ch0 and ch3 events together -> ch0 granted first.
